// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline stage registers.
// Stage payload structs are packed by the producing stage.
package pipe_pkg;

   typedef enum logic {
      PIPE_REG_READY  = 1'b0,
      PIPE_PASS_READY = 1'b1
   } pipe_mode_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } if_id_payload_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [3:0]  alu_op;
      logic        mem_rd;
      logic        mem_wr;
      logic        reg_wr;
   } id_ex_payload_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] result;
      logic [31:0] store_data;
      logic [4:0]  rd;
      logic        mem_rd;
      logic        mem_wr;
      logic        reg_wr;
   } ex_mem_payload_t;

   typedef struct packed {
      logic [31:0] wb_data;
      logic [4:0]  rd;
      logic        reg_wr;
   } mem_wb_payload_t;

   // Wrap by explicit compare so non-power-of-2 depths work.
   function automatic int unsigned ptr_inc(int unsigned ptr,
                                           int unsigned depth);
      return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/pipe_buf_mem.sv
// Payload storage for pipe_stage_buffer: one write port and
// an asynchronous read port.
module pipe_buf_mem #(
   parameter int DW    = 64,
   parameter int DEPTH = 2,
   parameter int AW    = 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_stage_buffer.sv
// Elastic valid/ready stage register with flush, occupancy count
// and a sticky upstream protocol monitor.
module pipe_stage_buffer
   import pipe_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 2,
   parameter int PIPE_READY = 1,
   parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  overflow_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);
   localparam pipe_mode_e MODE =
      (PIPE_READY != 0) ? PIPE_REG_READY : PIPE_PASS_READY;

   logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  err_q, err_d, pend_q, pend_d;
   logic [DATA_WIDTH-1:0] pdat_q, rdata;
   logic                  push, pop, empty;

   assign empty        = (cnt_q == '0);
   assign out_valid    = ~empty;
   assign out_data     = empty ? '0 : rdata;
   assign count        = cnt_q;
   assign overflow_err = err_q;

   generate
      if (MODE == PIPE_REG_READY) begin : g_reg
         logic rdy_q;
         always_ff @(posedge clk) begin
            if (!reset) rdy_q <= 1'b0;
            else        rdy_q <= (cnt_d != FULL);
         end
         assign in_ready = rdy_q;
      end else begin : g_pass
         assign in_ready = (cnt_q != FULL) | out_ready;
      end
   endgenerate

   assign push = in_valid & in_ready & ~flush;
   assign pop  = out_valid & out_ready & ~flush;

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (flush) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) wr_d = PW'(ptr_inc(32'(wr_q), DEPTH));
         if (pop)  rd_d = PW'(ptr_inc(32'(rd_q), DEPTH));
         if (push && !pop)      cnt_d = cnt_q + CNT_WIDTH'(1);
         else if (pop && !push) cnt_d = cnt_q - CNT_WIDTH'(1);
      end
   end

   // An unaccepted payload must be held unchanged on the next cycle.
   assign pend_d = in_valid & ~in_ready & ~flush;
   assign err_d  = err_q |
      (pend_q & (~in_valid | (in_data != pdat_q)));

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
         pend_q <= 1'b0;
         pdat_q <= '0;
      end else begin
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
         pend_q <= pend_d;
         pdat_q <= in_data;
      end
   end

   pipe_buf_mem #(
      .DW    (DATA_WIDTH),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_q),
      .wdata (in_data),
      .raddr (rd_q),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Random-stimulus bench: two buffer configurations checked against
// a queue-style reference model.
module tb_pipe_stage_buffer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst [2];
   logic       fl  [2];
   logic       iv  [2];
   logic       ordy[2];
   logic       irdy[2];
   logic       ov  [2];
   logic       oerr[2];
   logic [7:0] id  [2];
   logic [7:0] od  [2];
   logic [1:0] cnt [2];

   pipe_stage_buffer #(
      .DATA_WIDTH (8),
      .DEPTH      (2),
      .PIPE_READY (1)
   ) u_d0 (
      .clk          (clk),
      .reset        (rst[0]),
      .flush        (fl[0]),
      .in_valid     (iv[0]),
      .in_ready     (irdy[0]),
      .in_data      (id[0]),
      .out_valid    (ov[0]),
      .out_ready    (ordy[0]),
      .out_data     (od[0]),
      .count        (cnt[0]),
      .overflow_err (oerr[0])
   );

   pipe_stage_buffer #(
      .DATA_WIDTH (8),
      .DEPTH      (3),
      .PIPE_READY (0)
   ) u_d1 (
      .clk          (clk),
      .reset        (rst[1]),
      .flush        (fl[1]),
      .in_valid     (iv[1]),
      .in_ready     (irdy[1]),
      .in_data      (id[1]),
      .out_valid    (ov[1]),
      .out_ready    (ordy[1]),
      .out_data     (od[1]),
      .count        (cnt[1]),
      .overflow_err (oerr[1])
   );

   int         dep  [2];
   int         prm  [2];
   logic [7:0] mq   [2][4];
   int         mc   [2];
   bit         merr [2];
   bit         mpend[2];
   bit         mrl  [2];
   logic [7:0] mpd  [2];
   int         n_cmp = 0;
   int         n_err = 0;

   task automatic chk(string tag, logic [31:0] got,
                      logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int k, input int cyc);
      int rate;
      int ph;
      ph = (cyc / 64) % 3;
      rate = (ph == 0) ? 15 : ((ph == 1) ? 85 : 50);
      rst[k]  = ($urandom_range(0, 99) != 0);
      fl[k]   = ($urandom_range(0, 19) == 0);
      ordy[k] = ($urandom_range(0, 99) < rate);
      if (!(mpend[k] && $urandom_range(0, 79) != 0)) begin
         iv[k] = ($urandom_range(0, 99) < 70);
         id[k] = 8'($urandom);
      end
   endtask

   function automatic bit exp_ready(input int k);
      if (prm[k] != 0) return !mrl[k] && (mc[k] < dep[k]);
      return (mc[k] < dep[k]) || ordy[k];
   endfunction

   task automatic check(input int k);
      logic [7:0] ed;
      ed = (mc[k] != 0) ? mq[k][0] : 8'h00;
      chk($sformatf("d%0d in_ready", k), 32'(irdy[k]),
          32'(exp_ready(k)));
      chk($sformatf("d%0d out_valid", k), 32'(ov[k]),
          32'(mc[k] != 0));
      chk($sformatf("d%0d out_data", k), 32'(od[k]), 32'(ed));
      chk($sformatf("d%0d count", k), 32'(cnt[k]), 32'(mc[k]));
      chk($sformatf("d%0d overflow_err", k), 32'(oerr[k]),
          32'(merr[k]));
   endtask

   task automatic step(input int k);
      bit rdy;
      rdy = exp_ready(k);
      if (!rst[k]) begin
         mc[k]    = 0;
         merr[k]  = 1'b0;
         mpend[k] = 1'b0;
         mrl[k]   = 1'b1;
      end else begin
         mrl[k] = 1'b0;
         if (mpend[k] && (!iv[k] || id[k] != mpd[k]))
            merr[k] = 1'b1;
         mpend[k] = iv[k] && !rdy && !fl[k];
         mpd[k]   = id[k];
         if (fl[k]) begin
            mc[k] = 0;
         end else begin
            if (mc[k] > 0 && ordy[k]) begin
               for (int i = 0; i < 3; i++) mq[k][i] = mq[k][i+1];
               mc[k]--;
            end
            if (iv[k] && rdy) begin
               mq[k][mc[k]] = id[k];
               mc[k]++;
            end
         end
      end
   endtask

   initial begin
      dep[0] = 2;
      dep[1] = 3;
      prm[0] = 1;
      prm[1] = 0;
      for (int k = 0; k < 2; k++) begin
         mc[k]    = 0;
         merr[k]  = 1'b0;
         mpend[k] = 1'b0;
         mrl[k]   = 1'b1;
         mpd[k]   = 8'h00;
         rst[k]   = 1'b0;
         fl[k]    = 1'b0;
         iv[k]    = 1'b0;
         ordy[k]  = 1'b0;
         id[k]    = 8'h00;
      end
      repeat (2) @(posedge clk);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) drive(k, cyc);
         #1;
         for (int k = 0; k < 2; k++) begin
            check(k);
            step(k);
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
